pattern_det_ctrl: RTL
=====================

# pattern_det_ctrl

Configurable serial pattern-detection controller. A requester loads a pattern, a length and an overlap mode through a valid/ready handshake. The block then sequences detection over a qualified serial bit stream, emitting a one-cycle match pulse and keeping a saturating match count. It sits between the control side and the serial input path. It replaces fixed-pattern detectors with one runtime-programmable unit.

## Interface
- MAXLEN, 8: maximum pattern length in bits (2..16).
- CNTW, 8: width of the match counter.
- LW, $clog2(MAXLEN)+1: width of the length fields (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  high in IDLE and RUN; a transfer occurs when cfg_valid && cfg_ready at a clock edge.
- cfg_pattern  input  MAXLEN  pattern; bit [len-1] is the oldest bit and bit [0] the newest.
- cfg_len  input  LW  pattern length; legal range 1..MAXLEN.
- cfg_overlap  input  1  1 = overlapping detection; 0 = non-overlapping.
- stop  input  1  return to IDLE.
- in_valid  input  1  qualifies in.
- in  input  1  serial data bit.
- match  output  1  registered one-cycle match pulse.
- match_count  output  CNTW  saturating number of matches since the last accepted configuration.
- cfg_err  output  1  one-cycle pulse when a configuration with an illegal length is rejected.
- busy  output  1  high in ARM and RUN.

## Operation
- States: IDLE (unconfigured), ARM (one cycle), RUN.
- IDLE, on a cfg transfer with a legal length:
  - Latch pattern, length and overlap; go to ARM.
- IDLE, on a cfg transfer with cfg_len == 0 or cfg_len > MAXLEN:
  - Pulse cfg_err; stay in IDLE; leave the latched configuration unchanged.
- ARM:
  - Clear the history register hist[MAXLEN-1:0], the fill counter, match_count and match; go to RUN.
  - cfg_ready = 0 in ARM.
- RUN, per accepted bit (in_valid = 1):
  - hist <= {hist[MAXLEN-2:0], in}.
  - fill <= min(fill + 1, MAXLEN).
  - A match occurs when (fill + 1) >= len and the low len bits of the new hist equal the low len bits of the pattern.
- On a match:
  - match = 1 for the next cycle.
  - match_count increments, saturating at 2^CNTW - 1.
  - If overlap = 0, fill resets to 0, so the next match needs len fresh bits.
  - If overlap = 1, fill keeps counting.
- in_valid = 0: hist, fill and match_count hold; match = 0.
- RUN, on a cfg transfer:
  - Legal length: re-latch the configuration and go to ARM; the bit on in at that edge is discarded.
  - Illegal length: pulse cfg_err and continue RUN with the old configuration.
- Simultaneous events in RUN: stop has priority over cfg_valid. Stop goes to IDLE, no transfer occurs, and match_count holds its final value.
- IDLE/ARM: in is ignored and match = 0.
- Reset values: state = IDLE, match = 0, match_count = 0, cfg_err = 0, busy = 0, cfg_ready = 1, hist = 0, fill = 0. Pattern, length and overlap reset to 0.

## Timing
- Configuration-to-detection latency:
  - Cfg transfer at edge k → ARM during cycle k..k+1.
  - The first bit is sampled at edge k+2.
- Match latency: the completing bit is sampled at edge n → match is high from n to n+1, and match_count is updated at edge n.
- Back-to-back matches in overlap mode with len = 1 give match high on consecutive cycles.
- Asynchronous reset mid-RUN: all outputs go to their reset values immediately, with no pending match pulse. Operation resumes only after a new configuration.
- cfg_err is a registered pulse, high for the single cycle after the rejecting edge.

## Test plan
- Pattern 4'b1011, len 4, overlap 1; stream 1,0,1,1,0,1,1 with in_valid continuous → match after bits 4 and 7; match_count = 2.
- Same stream with overlap 0 → a single match after bit 4; match_count = 1.
- Pattern 2'b11, len 2; stream 1,1,1,1 → overlap: 3 matches. Non-overlap: 2 matches, after bits 2 and 4.
- Pattern 1011 with in_valid = 0 gaps inserted between bits, garbage on in during the gaps → identical match positions in valid-bit count; no match in gap cycles.
- CNTW = 2, pattern 1, len 1; 6 ones → match_count saturates at 3; match pulses 6 times.
- Edge cases:
  - cfg_len = 0 in IDLE → cfg_err pulse, state stays IDLE.
  - Reconfiguration in RUN → count cleared after ARM.
  - rst asserted mid-stream → match = 0, match_count = 0, busy = 0 without waiting for a clock edge.
  - stop and cfg_valid in the same cycle → IDLE; the count is retained.

Source files
------------

// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl: runtime-programmable serial pattern detector with saturating match count
// Ports: cfg_valid/cfg_ready/cfg_pattern/cfg_len/cfg_overlap configure; stop returns to IDLE;
// in_valid/in carry the serial stream; match pulses per detection; match_count saturates;
// cfg_err pulses on a rejected length; busy is high in ARM and RUN.
module pattern_det_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNTW = 8,
  localparam int LW = $clog2(MAXLEN) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_overlap,
  input  logic              stop,
  input  logic              in_valid,
  input  logic              in,
  output logic              match,
  output logic [CNTW-1:0]   match_count,
  output logic              cfg_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_n, mask;
  logic [LW-1:0] len_q, len_d, fill_q, fill_d, fill_n;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic ovl_q, ovl_d, match_q, match_d, err_q, err_d;
  logic legal, xfer, hit;
  assign cfg_ready = state_q != ARM;
  assign busy = state_q != IDLE;
  assign match = match_q;
  assign match_count = cnt_q;
  assign cfg_err = err_q;
  assign legal = cfg_len != '0 && cfg_len <= LW'(MAXLEN);
  // stop wins over a simultaneous request in RUN, so no transfer happens then
  assign xfer = cfg_valid && cfg_ready && !(state_q == RUN && stop);
  assign hist_n = {hist_q[MAXLEN-2:0], in};
  assign fill_n = fill_q + LW'(1);
  assign mask = ~({MAXLEN{1'b1}} << len_q);
  assign hit = fill_n >= len_q && ((hist_n ^ pat_q) & mask) == '0;
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d = cnt_q;
    match_d = 1'b0;
    err_d = xfer && !legal;
    if (state_q == ARM) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d = '0;
      state_d = RUN;
    end else if (state_q == RUN && stop) begin
      state_d = IDLE;
    end else if (xfer && legal) begin
      pat_d = cfg_pattern;
      len_d = cfg_len;
      ovl_d = cfg_overlap;
      state_d = ARM;
    end else if (state_q == RUN && in_valid) begin
      hist_d = hist_n;
      // non-overlapping mode restarts the fill so the next match needs len fresh bits
      fill_d = hit && !ovl_q ? '0 : (fill_n > LW'(MAXLEN) ? LW'(MAXLEN) : fill_n);
      cnt_d = hit ? cnt_q + CNTW'(cnt_q != '1) : cnt_q;
      match_d = hit;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q <= '0;
      match_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q <= cnt_d;
      match_q <= match_d;
      err_q <= err_d;
    end
  end
endmodule
